// File: rtl/mxint8_unpack_fp32.sv
// Dequantizes one MXINT8 block (E8M0 scale + BLOCK_SIZE int8 elements) and
// streams it out as BLOCK_SIZE IEEE-754 binary32 words in index order.
module mxint8_unpack_fp32 #(
   parameter int unsigned BLOCK_SIZE           = 32,
   parameter int unsigned SCALE_WIDTH          = 8,
   parameter int unsigned MXINT8_ELEMENT_WIDTH = 8,
   parameter int unsigned FLOAT32_WIDTH        = 32
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       i_blk_valid,
   output logic                                       o_blk_ready,
   input  logic [SCALE_WIDTH-1:0]                     i_scale,
   input  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements,
   output logic                                       o_elem_valid,
   input  logic                                       i_elem_ready,
   output logic [FLOAT32_WIDTH-1:0]                   o_float32,
   output logic [$clog2(BLOCK_SIZE)-1:0]              o_index,
   output logic                                       o_last,
   output logic                                       o_overflow
);

   localparam int unsigned IDX_W = $clog2(BLOCK_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

   typedef enum logic {
      S_IDLE,
      S_STREAM
   } state_e;

   state_e                                     state_q, state_d;
   logic [SCALE_WIDTH-1:0]                     scale_q, scale_d;
   logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] elems_q, elems_d;
   logic [IDX_W-1:0]                           index_q, index_d;

   logic [7:0]        elem;
   logic [7:0]        mag;
   logic [2:0]        lead;
   logic signed [9:0] exp_s;
   logic [22:0]       mag_w;
   logic [22:0]       frac_norm;
   logic [22:0]       frac_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         scale_q <= '0;
         elems_q <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         scale_q <= scale_d;
         elems_q <= elems_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      scale_d      = scale_q;
      elems_d      = elems_q;
      index_d      = index_q;
      o_blk_ready  = 1'b0;
      o_elem_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_blk_ready = 1'b1;
            if (i_blk_valid) begin
               scale_d = i_scale;
               elems_d = i_mxint8_elements;
               index_d = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            o_elem_valid = 1'b1;
            if (i_elem_ready) begin
               if (index_q == LAST_IDX) begin
                  index_d = '0;
                  state_d = S_IDLE;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_index = index_q;
      o_last  = (state_q == S_STREAM) && (index_q == LAST_IDX);
   end

   // 8-bit unsigned magnitude is enough: 0 - 8'h80 wraps to 128.
   always_comb begin
      elem = elems_q[{index_q, 3'b000} +: 8];
      mag  = elem[7] ? (8'd0 - elem) : elem;
      lead = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         if (mag[b]) lead = 3'(b);
      end
      exp_s     = $signed({2'b00, scale_q}) + $signed({7'b0000000, lead}) - 10'sd6;
      mag_w     = {15'b0, mag};
      // Shifting into a 23-bit field drops the hidden one off the top.
      frac_norm = mag_w << (5'd23 - {2'b00, lead});
      frac_sub  = mag_w << ({1'b0, scale_q} + 9'd16);
   end

   always_comb begin
      o_overflow = 1'b0;
      if (scale_q == 8'hFF) begin
         o_float32 = 32'h7FC0_0000;
      end else if (mag == 8'd0) begin
         o_float32 = '0;
      end else if (exp_s >= 10'sd255) begin
         o_float32  = {elem[7], 8'hFF, 23'd0};
         o_overflow = 1'b1;
      end else if (exp_s >= 10'sd1) begin
         o_float32 = {elem[7], exp_s[7:0], frac_norm};
      end else begin
         o_float32 = {elem[7], 8'h00, frac_sub};
      end
   end

endmodule

// File: tb/tb_mxint8_unpack_fp32.sv
// Directed, table-driven bench for mxint8_unpack_fp32 with hand-written
// sequences for backpressure, mid-stream reset and back-to-back blocks.
module tb_mxint8_unpack_fp32;

   localparam int unsigned BS = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_blk_valid = 1'b0;
   logic              o_blk_ready;
   logic [7:0]        i_scale = '0;
   logic [BS*8-1:0]   i_mxint8_elements = '0;
   logic              o_elem_valid;
   logic              i_elem_ready = 1'b0;
   logic [31:0]       o_float32;
   logic [4:0]        o_index;
   logic              o_last;
   logic              o_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  scale;
      logic [7:0]  elem;
      logic [31:0] exp_f;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[16];

   mxint8_unpack_fp32 #(.BLOCK_SIZE(BS)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_blk_valid       (i_blk_valid),
      .o_blk_ready       (o_blk_ready),
      .i_scale           (i_scale),
      .i_mxint8_elements (i_mxint8_elements),
      .o_elem_valid      (o_elem_valid),
      .i_elem_ready      (i_elem_ready),
      .o_float32         (o_float32),
      .o_index           (o_index),
      .o_last            (o_last),
      .o_overflow        (o_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Independent reference for scale 127 via double precision (all normal or zero).
   function automatic logic [31:0] ref_x127(input int e);
      real         v;
      logic [63:0] d;
      if (e == 0) return 32'h0;
      v = e * (1.0 / 64.0);
      d = $realtobits(v);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [BS*8-1:0] fill(input logic [7:0] e);
      logic [BS*8-1:0] r;
      for (int i = 0; i < BS; i++) r[i*8 +: 8] = e;
      return r;
   endfunction

   task automatic accept_block(input logic [7:0] sc, input logic [BS*8-1:0] el);
      int unsigned g = 0;
      @(negedge clk);
      while (!o_blk_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("blk_ready_wait", {31'b0, o_blk_ready}, 32'd1);
      i_scale           = sc;
      i_mxint8_elements = el;
      i_blk_valid       = 1'b1;
      @(posedge clk);
      #1 i_blk_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned g = 0;
      i_elem_ready = 1'b1;
      @(negedge clk);
      while (o_elem_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("drain_done", {31'b0, o_elem_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0]     exp_t1[4];
      logic [BS*8-1:0] blk;
      logic [31:0]     held;

      vecs[0]  = '{8'd127, 8'h40, 32'h3F80_0000, 1'b0};
      vecs[1]  = '{8'd127, 8'hE0, 32'hBF00_0000, 1'b0};
      vecs[2]  = '{8'd127, 8'h01, 32'h3C80_0000, 1'b0};
      vecs[3]  = '{8'd127, 8'h00, 32'h0000_0000, 1'b0};
      vecs[4]  = '{8'd0,   8'h40, 32'h0040_0000, 1'b0};
      vecs[5]  = '{8'd0,   8'h7F, 32'h007F_0000, 1'b0};
      vecs[6]  = '{8'd254, 8'h80, 32'hFF80_0000, 1'b1};
      vecs[7]  = '{8'd255, 8'h05, 32'h7FC0_0000, 1'b0};
      vecs[8]  = '{8'd255, 8'h00, 32'h7FC0_0000, 1'b0};
      vecs[9]  = '{8'd254, 8'h7F, 32'h7F7E_0000, 1'b0};
      vecs[10] = '{8'd0,   8'hFF, 32'h8001_0000, 1'b0};
      vecs[11] = '{8'd6,   8'h01, 32'h0040_0000, 1'b0};
      vecs[12] = '{8'd7,   8'h01, 32'h0080_0000, 1'b0};
      vecs[13] = '{8'd1,   8'h80, 32'h8100_0000, 1'b0};
      vecs[14] = '{8'd127, 8'h03, 32'h3D40_0000, 1'b0};
      vecs[15] = '{8'd5,   8'h03, 32'h0060_0000, 1'b0};

      exp_t1[0] = 32'h3F80_0000;
      exp_t1[1] = 32'hBF00_0000;
      exp_t1[2] = 32'h3C80_0000;
      exp_t1[3] = 32'h0000_0000;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_blk_ready", {31'b0, o_blk_ready}, 32'd1);
      chk("rst_elem_valid", {31'b0, o_elem_valid}, 32'd0);
      chk("rst_index", {27'b0, o_index}, 32'd0);
      chk("rst_last", {31'b0, o_last}, 32'd0);
      chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
      chk("rst_float", o_float32, 32'd0);
      rst_n = 1'b1;

      // Basic stream: X=127, {64,-32,1,0}, rest zero
      i_elem_ready = 1'b1;
      blk = '0;
      blk[7:0]   = 8'd64;
      blk[15:8]  = 8'hE0;
      blk[23:16] = 8'd1;
      accept_block(8'd127, blk);
      for (int k = 0; k < BS; k++) begin
         @(negedge clk);
         chk("t1_valid", {31'b0, o_elem_valid}, 32'd1);
         chk("t1_index", {27'b0, o_index}, k);
         chk("t1_last", {31'b0, o_last}, (k == BS - 1) ? 32'd1 : 32'd0);
         chk("t1_float", o_float32, (k < 4) ? exp_t1[k] : 32'd0);
      end
      @(negedge clk);
      chk("t1_blk_ready_after", {31'b0, o_blk_ready}, 32'd1);
      chk("t1_valid_after", {31'b0, o_elem_valid}, 32'd0);

      // Conversion table: whole block filled with one element
      foreach (vecs[v]) begin
         accept_block(vecs[v].scale, fill(vecs[v].elem));
         for (int k = 0; k < BS; k++) begin
            @(negedge clk);
            if (k == 0 || k == BS - 1) begin
               chk("vec_float", o_float32, vecs[v].exp_f);
               chk("vec_ovf", {31'b0, o_overflow}, {31'b0, vecs[v].exp_ovf});
            end
         end
      end

      // X=255 with random elements
      for (int i = 0; i < BS * 8 / 32; i++) blk[i*32 +: 32] = $urandom;
      accept_block(8'hFF, blk);
      for (int k = 0; k < BS; k++) begin
         @(negedge clk);
         chk("nan_float", o_float32, 32'h7FC0_0000);
         chk("nan_ovf", {31'b0, o_overflow}, 32'd0);
      end

      // Backpressure at index 3 with a stray block offered meanwhile
      for (int k = 0; k < BS; k++) blk[k*8 +: 8] = 8'(k - 16);
      accept_block(8'd127, blk);
      for (int k = 0; k < BS; k++) begin
         @(negedge clk);
         chk("bp_index", {27'b0, o_index}, k);
         chk("bp_float", o_float32, ref_x127(k - 16));
         if (k == 3) begin
            held              = o_float32;
            i_elem_ready      = 1'b0;
            i_blk_valid       = 1'b1;
            i_scale           = 8'hFF;
            i_mxint8_elements = fill(8'h55);
            repeat (5) begin
               @(negedge clk);
               chk("bp_hold_valid", {31'b0, o_elem_valid}, 32'd1);
               chk("bp_hold_index", {27'b0, o_index}, 32'd3);
               chk("bp_hold_float", o_float32, held);
               chk("bp_hold_last", {31'b0, o_last}, 32'd0);
               chk("bp_hold_blk_ready", {31'b0, o_blk_ready}, 32'd0);
            end
            i_elem_ready = 1'b1;
            i_blk_valid  = 1'b0;
         end
      end
      @(negedge clk);
      chk("bp_done_valid", {31'b0, o_elem_valid}, 32'd0);

      // Asynchronous reset mid-stream at index 10
      accept_block(8'd127, fill(8'd64));
      for (int k = 0; k <= 10; k++) @(negedge clk);
      chk("ar_index_before", {27'b0, o_index}, 32'd10);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, o_elem_valid}, 32'd0);
      chk("ar_blk_ready", {31'b0, o_blk_ready}, 32'd1);
      chk("ar_index", {27'b0, o_index}, 32'd0);
      chk("ar_float", o_float32, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      accept_block(8'd127, fill(8'hE0));
      @(negedge clk);
      chk("ar_new_index", {27'b0, o_index}, 32'd0);
      chk("ar_new_float", o_float32, 32'hBF00_0000);
      drain();

      // Back-to-back blocks with i_blk_valid held high
      @(negedge clk);
      i_elem_ready      = 1'b1;
      i_scale           = 8'd127;
      i_mxint8_elements = fill(8'd64);
      i_blk_valid       = 1'b1;
      @(posedge clk);
      #1 i_mxint8_elements = fill(8'd1);
      for (int k = 0; k < BS; k++) begin
         @(negedge clk);
         chk("b2b_first_float", o_float32, 32'h3F80_0000);
         chk("b2b_first_blk_ready", {31'b0, o_blk_ready}, 32'd0);
      end
      @(negedge clk);
      chk("b2b_gap_blk_ready", {31'b0, o_blk_ready}, 32'd1);
      chk("b2b_gap_valid", {31'b0, o_elem_valid}, 32'd0);
      @(posedge clk);
      #1 i_blk_valid = 1'b0;
      @(negedge clk);
      chk("b2b_second_valid", {31'b0, o_elem_valid}, 32'd1);
      chk("b2b_second_index", {27'b0, o_index}, 32'd0);
      chk("b2b_second_float", o_float32, 32'h3C80_0000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mxint8_unpack_fp32.md
Name: mxint8_unpack_fp32

Overview:
- Inverse of the float32-to-MXINT8 broadcast path: dequantizes one MXINT8 block (E8M0 shared scale plus BLOCK_SIZE 8-bit elements) back to float32.
- Accepts a whole block in one handshake, then streams it out as BLOCK_SIZE float32 words, one per handshake, in index order.
- Sits between MX block storage and scalar FP32 consumers, and serves as the checker-side inverse in MX ALU benches.

Parameters:
- BLOCK_SIZE, 32, elements per MX block (power of two, 2..64)
- SCALE_WIDTH, 8, E8M0 shared-scale width (fixed by format)
- MXINT8_ELEMENT_WIDTH, 8, element width (fixed by format)
- FLOAT32_WIDTH, 32, output word width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_blk_valid  in  1  input block valid
- o_blk_ready  out  1  block accepted when i_blk_valid && o_blk_ready
- i_scale  in  SCALE_WIDTH  E8M0 shared scale X
- i_mxint8_elements  in  BLOCK_SIZE*8  packed elements; element k occupies bits [8k+7:8k], two's complement
- o_elem_valid  out  1  output word valid
- i_elem_ready  in  1  word consumed when o_elem_valid && i_elem_ready
- o_float32  out  32  IEEE-754 binary32 value of the current element
- o_index  out  $clog2(BLOCK_SIZE)  index of the current element
- o_last  out  1  current word is index BLOCK_SIZE-1
- o_overflow  out  1  current word overflowed to infinity

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-stream):
  - state=IDLE, o_blk_ready=1, o_elem_valid=0, o_index=0, o_last=0, o_overflow=0, o_float32=0
  - stored scale and elements cleared; any partially streamed block is discarded
- State machine, two states:
  - IDLE: o_blk_ready=1, o_elem_valid=0. On block handshake, register i_scale and all elements, index=0, go to STREAM.
  - STREAM: o_blk_ready=0, o_elem_valid=1. On word handshake:
    - index < BLOCK_SIZE-1: index+1, stay in STREAM.
    - index = BLOCK_SIZE-1: go to IDLE.
    - No handshake: o_float32, o_index, o_last and o_overflow hold stable.
- Timing:
  - Block accepted at edge N gives word 0 valid in cycle N+1.
  - With i_elem_ready held high, one word per cycle; block throughput is BLOCK_SIZE+1 cycles.
  - o_blk_ready rises in the cycle after the last handshake.
  - Blocks are never accepted while in STREAM.
- Output datapath:
  - o_float32 is combinational from the registered scale, the registered elements and the index register only.
  - No combinational path from any input port to any output port.
- Conversion, element e, scale X; value = e * 2^-6 * 2^(X-127):
  - X=255: 0x7FC00000 for every element, o_overflow=0.
  - e=0: 0x00000000 (positive zero).
  - Otherwise:
    - sign = e[7]; m = |e|, range 1..128 (9-bit intermediate so that -128 is safe).
    - p = leading-one position of m, 0..7; E = X + p - 6, signed 10-bit.
    - E >= 255: sign|0x7F800000 with o_overflow=1 (only X=254, e=-128).
    - 1 <= E <= 254 (normal): exponent field = E; fraction = (m with its leading one removed) << (23-p).
    - E <= 0 (subnormal): exponent field = 0; fraction = m << (X+16). X+16 <= 22 whenever E <= 0, so the fraction always fits and the result is exact.
- Exactness: every result is exact; no rounding logic exists.
- Handshake rules:
  - i_elem_ready may toggle freely.
  - o_elem_valid never drops until its handshake completes, except on reset.
  - i_blk_valid asserted during STREAM is ignored; input data is not sampled.

Test Plan:
- Reset release, X=127, elements[0..3] = {64, -32, 1, 0}, rest 0, i_elem_ready=1:
  - Word 0 valid one cycle after accept.
  - Outputs 0x3F800000, 0xBF000000, 0x3C800000, 0x00000000.
  - o_index 0..BLOCK_SIZE-1; o_last only on index 31.
  - o_blk_ready high again 33 cycles after accept.
- Subnormal and overflow:
  - X=0, e=64 gives 0x00400000; X=0, e=127 gives 0x007F0000.
  - X=254, e=-128 gives 0xFF800000 with o_overflow=1.
- X=255 with random elements: all 32 words 0x7FC00000, o_overflow=0.
- Backpressure: i_elem_ready low for 5 cycles at index 3:
  - o_float32, o_index and o_last stable throughout.
  - No word skipped or duplicated.
  - i_blk_valid pulsed meanwhile is not accepted.
- Async reset asserted at index 10, mid-clock:
  - o_elem_valid drops immediately and o_blk_ready=1.
  - A new block after release starts at index 0.
- Back-to-back blocks with i_blk_valid held high: second block accepted exactly in the cycle after the first block's last handshake.
